swacc_cxt_wr_engine: RTL and testbench
======================================

# swacc_cxt_wr_engine

Parametrised CEU context-write engine for the SWAccCMCtl software-access path. It accepts a multi-beat context write command (QPC/CQC/EQC/MPT, selected by parameters) from SWAccCMCtl_Thread_0. It translates the context index through the ICM mapping table and issues one cache set/modify/invalidate request to the owning ICMCache. Unlike the fixed CQC handler, it buffers the whole entry, overlaps address lookup with data collection, forwards invalidates, and drains malformed commands with error reporting.

## Interface
- HEAD_WIDTH, 128, command head width; opcode at [123:120], index at [95:64]
- DATA_WIDTH, 256, beat data width
- PIECE_NUM, 2, beats per WR_ALL/WR_MODIFY command (1..8)
- ENTRY_WIDTH, 512, cache entry width (≤ PIECE_NUM*DATA_WIDTH)
- INDEX_WIDTH, 14, ICM lookup index width (low bits of command index)
- ICM_ADDR_WIDTH, 64 / PHY_ADDR_WIDTH, 64, address widths
- TAG_WIDTH, 4 / COUNT_WIDTH, 2, tag and count field widths; tag driven 0, count_max 1, count_index 0
- OP_WR_ALL, OP_WR_MODIFY, OP_WR_INVALID, 4-bit opcode codes
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid/req_ready  in/out  1  command beat handshake
- req_head  in  HEAD_WIDTH  command head, valid on every beat, sampled on first beat
- req_last  in  1  final beat of command
- req_data  in  DATA_WIDTH  beat payload
- lookup_valid/lookup_ready  out/in  1  ICM lookup handshake
- lookup_head  out  INDEX_WIDTH  context index
- rsp_valid/rsp_ready  in/out  1  mapping response handshake
- rsp_icm_addr, rsp_phy_addr  in  ICM/PHY_ADDR_WIDTH  translated addresses
- set_valid/set_ready  out/in  1  cache request handshake
- set_head  out  TAG+2*COUNT+ICM+PHY  {tag, count_max, count_index, phy_addr, icm_addr}
- set_op  out  2  0 set-all, 1 modify, 2 invalidate
- set_data  out  ENTRY_WIDTH  buffered entry (zero for invalidate)
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  1 unknown opcode, 2 short command, 3 long command; held until next error

## Operation
- States: IDLE, LOOKUP, COLLECT, DRAIN, SET.
- IDLE: req_ready=0. On req_valid, latch head, clear beat counter, buffer, rsp_got, data_done, err flag. A known opcode goes to LOOKUP. An unknown opcode goes to DRAIN with err_code=1.
- LOOKUP: lookup_valid=1, lookup_head=index[INDEX_WIDTH-1:0]. On lookup_ready, go to COLLECT. Beats are accepted in LOOKUP too.
- Beat acceptance (LOOKUP/COLLECT): req_ready=!data_done. Beat k is written to buffer[k*DATA_WIDTH +: DATA_WIDTH]. The counter saturates at PIECE_NUM. The expected count is PIECE_NUM for WR_ALL/MODIFY and 1 for INVALID.
  - last on beat k+1 == expected: data_done=1.
  - last with fewer beats: data_done=1, err flag, code 2.
  - expected beats seen without last: further beats are consumed but not stored until last, then data_done=1, err flag, code 3.
- COLLECT: rsp_ready=1 until rsp_got. On rsp handshake, latch addresses and set rsp_got. When rsp_got && data_done:
  - err flag clear: go to SET.
  - err flag set: pulse err_valid, go to IDLE with no cache request.
- DRAIN: req_ready=1. On the last beat handshake, pulse err_valid and go to IDLE. No lookup is issued.
- SET: set_valid=1, set_op from opcode, set_data = buffer[ENTRY_WIDTH-1:0] (all zero for invalidate). Go to IDLE on set_ready.
- set_head/lookup_head are zero outside SET/LOOKUP. set_data is held stable while set_valid=1.
- Reset (rst=0, any state): state IDLE. All valid/ready outputs, err_valid, err_code, set_* and lookup_head go to 0. The buffer is cleared. Any in-flight command is abandoned.

## Timing
- All outputs are registered-state decodes. There is no combinational path from any input to any valid/ready output.
- Command valid at cycle 0 gives LOOKUP at cycle 1, with lookup_valid and req_ready high.
- Best case, PIECE_NUM=2 with ready lookup and response at cycle 2: beats accepted at cycles 1–2, SET at cycle 3, set handshake at cycle 3 if set_ready=1, IDLE at cycle 4.
- A response arriving before the data is complete is held. Data completing before the response waits in COLLECT.
- Simultaneous final beat and rsp handshake in COLLECT: the next state is SET (or IDLE on error).
- Throughput: one command per (max(beats, lookup+rsp) + 2) cycles. There is no back-to-back overlap across commands.

## Test plan
- WR_ALL, PIECE_NUM=2, index 0x25, beats 0xA…/0xB…, rsp icm=0x1000 phy=0x8000 -> lookup_head=0x25; one set with op 0, head {0,1,0,0x8000,0x1000}, data {0xB…,0xA…}.
- WR_INVALID single beat with last -> lookup issued; set op 2, data 0, correct addresses; no error.
- Unknown opcode 0xF, 3 beats -> no lookup, 3 beats consumed, err_valid pulse with code 1, back to IDLE.
- WR_MODIFY with last on beat 1 (short) -> response still consumed, no set, err code 2. WR_ALL with 4 beats -> 4 beats consumed, no set, err code 3.
- Response arrives 10 cycles before the final beat; set_ready held low 5 cycles in SET -> addresses retained; set_valid and data stable until the handshake.
- Assert rst=0 mid-COLLECT -> all outputs 0 immediately. After release, a fresh WR_ALL completes normally.

Source files
------------

// File: rtl/swacc_cxt_wr_engine_if.sv
// Bundle of the command, ICM lookup, mapping response, cache request and
// error report channels of the CEU context-write engine.
interface swacc_cxt_wr_engine_if #(
    parameter int HEAD_WIDTH     = 128,
    parameter int DATA_WIDTH     = 256,
    parameter int ENTRY_WIDTH    = 512,
    parameter int INDEX_WIDTH    = 14,
    parameter int ICM_ADDR_WIDTH = 64,
    parameter int PHY_ADDR_WIDTH = 64,
    parameter int TAG_WIDTH      = 4,
    parameter int COUNT_WIDTH    = 2
);
    localparam int SET_HEAD_WIDTH = TAG_WIDTH + 2 * COUNT_WIDTH + ICM_ADDR_WIDTH + PHY_ADDR_WIDTH;

    logic                      req_valid;
    logic                      req_ready;
    logic [HEAD_WIDTH-1:0]     req_head;
    logic                      req_last;
    logic [DATA_WIDTH-1:0]     req_data;

    logic                      lookup_valid;
    logic                      lookup_ready;
    logic [INDEX_WIDTH-1:0]    lookup_head;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ICM_ADDR_WIDTH-1:0] rsp_icm_addr;
    logic [PHY_ADDR_WIDTH-1:0] rsp_phy_addr;

    logic                      set_valid;
    logic                      set_ready;
    logic [SET_HEAD_WIDTH-1:0] set_head;
    logic [1:0]                set_op;
    logic [ENTRY_WIDTH-1:0]    set_data;

    logic                      err_valid;
    logic [1:0]                err_code;

    // engine side
    modport master (
        input  req_valid, req_head, req_last, req_data,
        output req_ready,
        output lookup_valid, lookup_head,
        input  lookup_ready,
        input  rsp_valid, rsp_icm_addr, rsp_phy_addr,
        output rsp_ready,
        output set_valid, set_head, set_op, set_data,
        input  set_ready,
        output err_valid, err_code
    );

    // thread / mapping table / cache side
    modport slave (
        output req_valid, req_head, req_last, req_data,
        input  req_ready,
        input  lookup_valid, lookup_head,
        output lookup_ready,
        output rsp_valid, rsp_icm_addr, rsp_phy_addr,
        input  rsp_ready,
        input  set_valid, set_head, set_op, set_data,
        output set_ready,
        input  err_valid, err_code
    );
endinterface

// File: rtl/swacc_cxt_wr_engine.sv
// CEU context-write engine: buffers a multi-beat context write, translates
// the context index through the ICM mapping table while the data is still
// arriving, then issues one set/modify/invalidate request to the cache.
// Malformed commands are drained and reported on the error channel.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a command head, nothing accepted
// LOOKUP  | lookup request outstanding, beats accepted
// COLLECT | waiting for mapping response and/or remaining beats
// DRAIN   | unknown opcode, consuming beats up to last, then report
// SET     | cache request outstanding, entry held stable
module swacc_cxt_wr_engine #(
    parameter int HEAD_WIDTH     = 128,
    parameter int DATA_WIDTH     = 256,
    parameter int PIECE_NUM      = 2,
    parameter int ENTRY_WIDTH    = 512,
    parameter int INDEX_WIDTH    = 14,
    parameter int ICM_ADDR_WIDTH = 64,
    parameter int PHY_ADDR_WIDTH = 64,
    parameter int TAG_WIDTH      = 4,
    parameter int COUNT_WIDTH    = 2,
    parameter logic [3:0] OP_WR_ALL     = 4'h1,
    parameter logic [3:0] OP_WR_MODIFY  = 4'h2,
    parameter logic [3:0] OP_WR_INVALID = 4'h3
) (
    input  logic clk,
    input  logic rst,
    swacc_cxt_wr_engine_if.master bus
);
    localparam int BUF_WIDTH      = PIECE_NUM * DATA_WIDTH;
    localparam int CNT_WIDTH      = 4;
    localparam int SET_HEAD_WIDTH = TAG_WIDTH + 2 * COUNT_WIDTH + ICM_ADDR_WIDTH + PHY_ADDR_WIDTH;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOOKUP  = 3'd1;
    localparam logic [2:0] ST_COLLECT = 3'd2;
    localparam logic [2:0] ST_DRAIN   = 3'd3;
    localparam logic [2:0] ST_SET     = 3'd4;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_OPCODE = 2'd1;
    localparam logic [1:0] ERR_SHORT  = 2'd2;
    localparam logic [1:0] ERR_LONG   = 2'd3;

    localparam logic [1:0] SOP_ALL     = 2'd0;
    localparam logic [1:0] SOP_MODIFY  = 2'd1;
    localparam logic [1:0] SOP_INVALID = 2'd2;

    logic [2:0]                state_q, state_n;
    logic [3:0]                opcode_q, opcode_n;
    logic [INDEX_WIDTH-1:0]    index_q, index_n;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_n;
    logic [BUF_WIDTH-1:0]      buf_q, buf_n;
    logic                      data_done_q, data_done_n;
    logic                      err_flag_q, err_flag_n;
    logic [1:0]                err_pend_q, err_pend_n;
    logic                      rsp_got_q, rsp_got_n;
    logic [ICM_ADDR_WIDTH-1:0] icm_q, icm_n;
    logic [PHY_ADDR_WIDTH-1:0] phy_q, phy_n;
    logic                      err_valid_q, err_valid_n;
    logic [1:0]                err_code_q, err_code_n;

    logic                      req_ready;
    logic                      rsp_ready;
    logic                      beat_hs;
    logic [CNT_WIDTH-1:0]      exp_beats;
    logic [3:0]                new_opcode;
    logic [1:0]                set_op;

    // Only the opcode and the low index bits of the head are ever used.
    logic unused_head;
    assign unused_head = ^bus.req_head;

    function automatic logic op_known(input logic [3:0] op);
        return (op == OP_WR_ALL) || (op == OP_WR_MODIFY) || (op == OP_WR_INVALID);
    endfunction

    assign new_opcode = bus.req_head[123:120];
    assign exp_beats  = (opcode_q == OP_WR_INVALID) ? CNT_WIDTH'(1) : CNT_WIDTH'(PIECE_NUM);

    assign req_ready  = (((state_q == ST_LOOKUP) || (state_q == ST_COLLECT)) && !data_done_q)
                        || (state_q == ST_DRAIN);
    assign rsp_ready  = (state_q == ST_COLLECT) && !rsp_got_q;
    assign beat_hs    = req_ready && bus.req_valid;

    // Next-state and datapath update for the whole command lifecycle.
    always_comb begin
        state_n     = state_q;
        opcode_n    = opcode_q;
        index_n     = index_q;
        cnt_n       = cnt_q;
        buf_n       = buf_q;
        data_done_n = data_done_q;
        err_flag_n  = err_flag_q;
        err_pend_n  = err_pend_q;
        rsp_got_n   = rsp_got_q;
        icm_n       = icm_q;
        phy_n       = phy_q;
        err_valid_n = 1'b0;
        err_code_n  = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    opcode_n    = new_opcode;
                    index_n     = bus.req_head[64 +: INDEX_WIDTH];
                    cnt_n       = '0;
                    buf_n       = '0;
                    data_done_n = 1'b0;
                    err_flag_n  = 1'b0;
                    rsp_got_n   = 1'b0;
                    if (op_known(new_opcode)) begin
                        err_pend_n = ERR_NONE;
                        state_n    = ST_LOOKUP;
                    end else begin
                        err_pend_n = ERR_OPCODE;
                        state_n    = ST_DRAIN;
                    end
                end
            end

            ST_LOOKUP, ST_COLLECT: begin
                if (beat_hs) begin
                    for (int k = 0; k < PIECE_NUM; k++) begin
                        if ((cnt_q == CNT_WIDTH'(k)) && (cnt_q < exp_beats))
                            buf_n[k*DATA_WIDTH +: DATA_WIDTH] = bus.req_data;
                    end
                    if (cnt_q < CNT_WIDTH'(PIECE_NUM))
                        cnt_n = cnt_q + CNT_WIDTH'(1);
                    if (bus.req_last) begin
                        data_done_n = 1'b1;
                        if (cnt_q >= exp_beats) begin
                            err_flag_n = 1'b1;
                            err_pend_n = ERR_LONG;
                        end else if ((cnt_q + CNT_WIDTH'(1)) < exp_beats) begin
                            err_flag_n = 1'b1;
                            err_pend_n = ERR_SHORT;
                        end
                    end
                end

                if (state_q == ST_LOOKUP) begin
                    if (bus.lookup_ready)
                        state_n = ST_COLLECT;
                end else begin
                    if (rsp_ready && bus.rsp_valid) begin
                        icm_n     = bus.rsp_icm_addr;
                        phy_n     = bus.rsp_phy_addr;
                        rsp_got_n = 1'b1;
                    end
                    // Final beat and response may land in the same cycle.
                    if (rsp_got_n && data_done_n) begin
                        if (err_flag_n) begin
                            err_valid_n = 1'b1;
                            err_code_n  = err_pend_n;
                            state_n     = ST_IDLE;
                        end else begin
                            state_n     = ST_SET;
                        end
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.req_valid && bus.req_last) begin
                    err_valid_n = 1'b1;
                    err_code_n  = err_pend_q;
                    state_n     = ST_IDLE;
                end
            end

            ST_SET: begin
                if (bus.set_ready)
                    state_n = ST_IDLE;
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            opcode_q    <= '0;
            index_q     <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            data_done_q <= 1'b0;
            err_flag_q  <= 1'b0;
            err_pend_q  <= ERR_NONE;
            rsp_got_q   <= 1'b0;
            icm_q       <= '0;
            phy_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_n;
            opcode_q    <= opcode_n;
            index_q     <= index_n;
            cnt_q       <= cnt_n;
            buf_q       <= buf_n;
            data_done_q <= data_done_n;
            err_flag_q  <= err_flag_n;
            err_pend_q  <= err_pend_n;
            rsp_got_q   <= rsp_got_n;
            icm_q       <= icm_n;
            phy_q       <= phy_n;
            err_valid_q <= err_valid_n;
            err_code_q  <= err_code_n;
        end
    end

    // Cache operation derived from the latched opcode.
    always_comb begin
        set_op = SOP_ALL;
        if (opcode_q == OP_WR_MODIFY)
            set_op = SOP_MODIFY;
        else if (opcode_q == OP_WR_INVALID)
            set_op = SOP_INVALID;
    end

    assign bus.req_ready    = req_ready;
    assign bus.rsp_ready    = rsp_ready;
    assign bus.lookup_valid = (state_q == ST_LOOKUP);
    assign bus.lookup_head  = (state_q == ST_LOOKUP) ? index_q : '0;
    assign bus.set_valid    = (state_q == ST_SET);
    assign bus.set_op       = (state_q == ST_SET) ? set_op : 2'd0;
    assign bus.set_head     = (state_q == ST_SET)
                              ? {TAG_WIDTH'(0), COUNT_WIDTH'(1), COUNT_WIDTH'(0), phy_q, icm_q}
                              : SET_HEAD_WIDTH'(0);
    assign bus.set_data     = ((state_q == ST_SET) && (opcode_q != OP_WR_INVALID))
                              ? buf_q[ENTRY_WIDTH-1:0] : '0;
    assign bus.err_valid    = err_valid_q;
    assign bus.err_code     = err_code_q;
endmodule

// File: tb/tb_swacc_cxt_wr_engine.sv
// Directed bench for the CEU context-write engine: a table of commands with
// hand-computed outcomes plus a mid-command reset sequence.
module tb_swacc_cxt_wr_engine;
    localparam logic [3:0] OP_ALL = 4'h1;
    localparam logic [3:0] OP_MOD = 4'h2;
    localparam logic [3:0] OP_INV = 4'h3;
    localparam int         BUDGET = 300;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] idx;
        int          nbeats;
        int          last_hold;
        int          rsp_at;
        int          set_hold;
        logic [63:0] icm;
        logic [63:0] phy;
        int          exp_lookups;
        int          exp_sets;
        logic [1:0]  exp_op;
        logic [1:0]  exp_err;
        int          exp_set_cycle;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [7];

    swacc_cxt_wr_engine_if bus ();

    swacc_cxt_wr_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] beat_val(input int k, input int vi);
        logic [31:0] w;
        w = 32'hA0A0_A0A0 + 32'h1010_1010 * 32'(k) + 32'(vi);
        return {8{w}};
    endfunction

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_head     = '0;
        bus.req_last     = 1'b0;
        bus.req_data     = '0;
        bus.lookup_ready = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.rsp_icm_addr = '0;
        bus.rsp_phy_addr = '0;
        bus.set_ready    = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " req_ready"},    bus.req_ready,    0);
        chk({tag, " lookup_valid"}, bus.lookup_valid, 0);
        chk({tag, " rsp_ready"},    bus.rsp_ready,    0);
        chk({tag, " set_valid"},    bus.set_valid,    0);
        chk({tag, " err_valid"},    bus.err_valid,    0);
        chk({tag, " err_code"},     bus.err_code,     0);
        chk({tag, " lookup_head"},  bus.lookup_head,  0);
        chk({tag, " set_head"},     bus.set_head,     0);
        chk({tag, " set_op"},       bus.set_op,       0);
        chk({tag, " set_data"},     bus.set_data,     0);
    endtask

    task automatic run_cmd(input vec_t v, input int vi);
        int           cyc, sent, lookups, rsp_given, sets, errs, set_cnt, set_cyc, lk_cyc, tail;
        bit           stable, heads_ok, lk_head_ok, is_last;
        logic [1:0]   got_op, got_err;
        logic [135:0] got_head, first_head, exp_head;
        logic [511:0] got_data, first_data, exp_data;
        logic [127:0] head;

        cyc = 0; sent = 0; lookups = 0; rsp_given = 0; sets = 0; errs = 0;
        set_cnt = 0; set_cyc = -1; lk_cyc = -1; tail = -1;
        stable = 1; heads_ok = 1; lk_head_ok = 1;
        got_op = '0; got_err = '0; got_head = '0; first_head = '0; got_data = '0; first_data = '0;
        head = '0;
        head[123:120] = v.op;
        head[95:64]   = v.idx;

        while (tail < 3 && cyc < BUDGET) begin
            @(negedge clk);
            if (!bus.lookup_valid && bus.lookup_head != '0) heads_ok = 0;
            if (!bus.set_valid && bus.set_head != '0) heads_ok = 0;
            if (bus.err_valid) begin
                errs++;
                got_err = bus.err_code;
            end

            if (sent < v.nbeats && !(sent == v.nbeats - 1 && cyc < v.last_hold)) begin
                is_last       = (sent == v.nbeats - 1);
                bus.req_valid = 1'b1;
                bus.req_head  = head;
                bus.req_data  = beat_val(sent, vi);
                bus.req_last  = is_last;
                if (bus.req_ready) sent++;
            end else begin
                bus.req_valid = 1'b0;
                bus.req_last  = 1'b0;
            end

            bus.lookup_ready = 1'b1;
            if (bus.lookup_valid) begin
                lookups++;
                lk_cyc = cyc;
                if (bus.lookup_head !== v.idx[13:0]) lk_head_ok = 0;
            end

            if (lookups > 0 && cyc >= v.rsp_at && rsp_given == 0) begin
                bus.rsp_valid    = 1'b1;
                bus.rsp_icm_addr = v.icm;
                bus.rsp_phy_addr = v.phy;
                if (bus.rsp_ready) rsp_given++;
            end else begin
                bus.rsp_valid = 1'b0;
            end

            if (bus.set_valid) begin
                if (set_cnt == 0) begin
                    first_head = bus.set_head;
                    first_data = bus.set_data;
                end else if (bus.set_head !== first_head || bus.set_data !== first_data) begin
                    stable = 0;
                end
                if (set_cnt >= v.set_hold) begin
                    bus.set_ready = 1'b1;
                    sets++;
                    set_cyc  = cyc;
                    got_op   = bus.set_op;
                    got_head = bus.set_head;
                    got_data = bus.set_data;
                    set_cnt  = 0;
                end else begin
                    bus.set_ready = 1'b0;
                    set_cnt++;
                end
            end else begin
                bus.set_ready = 1'b0;
            end

            if (tail >= 0) tail++;
            else if (sent == v.nbeats && (sets + errs) > 0) tail = 0;
            cyc++;
        end
        @(negedge clk);
        idle_inputs();

        exp_head = {4'h0, 2'd1, 2'd0, v.phy, v.icm};
        exp_data = '0;
        if (v.op != OP_INV) begin
            for (int k = 0; k < 2; k++) exp_data[k*256 +: 256] = beat_val(k, vi);
        end

        chk($sformatf("v%0d completed", vi), tail >= 3, 1);
        chk($sformatf("v%0d beats consumed", vi), sent, v.nbeats);
        chk($sformatf("v%0d lookups", vi), lookups, v.exp_lookups);
        if (v.exp_lookups > 0) begin
            chk($sformatf("v%0d lookup_head", vi), lk_head_ok, 1);
            chk($sformatf("v%0d lookup cycle", vi), lk_cyc, 1);
            chk($sformatf("v%0d rsp consumed", vi), rsp_given, 1);
        end
        chk($sformatf("v%0d sets", vi), sets, v.exp_sets);
        if (v.exp_sets > 0) begin
            chk($sformatf("v%0d set_op", vi), got_op, v.exp_op);
            chk($sformatf("v%0d set_head", vi), got_head, exp_head);
            chk($sformatf("v%0d set_data", vi), got_data, exp_data);
            chk($sformatf("v%0d set stable", vi), stable, 1);
            if (v.exp_set_cycle >= 0)
                chk($sformatf("v%0d set cycle", vi), set_cyc, v.exp_set_cycle);
        end
        chk($sformatf("v%0d err pulses", vi), errs, (v.exp_err != 2'd0) ? 1 : 0);
        if (v.exp_err != 2'd0)
            chk($sformatf("v%0d err_code", vi), got_err, v.exp_err);
        chk($sformatf("v%0d idle heads zero", vi), heads_ok, 1);
    endtask

    initial begin
        logic [127:0] head;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle_inputs();

        vecs[0] = '{op:OP_ALL, idx:32'h0000_0025, nbeats:2, last_hold:0, rsp_at:2, set_hold:0,
                    icm:64'h1000, phy:64'h8000, exp_lookups:1, exp_sets:1, exp_op:2'd0,
                    exp_err:2'd0, exp_set_cycle:3};
        vecs[1] = '{op:OP_INV, idx:32'h0001_5ABC, nbeats:1, last_hold:0, rsp_at:2, set_hold:0,
                    icm:64'h2000, phy:64'h9000, exp_lookups:1, exp_sets:1, exp_op:2'd2,
                    exp_err:2'd0, exp_set_cycle:3};
        vecs[2] = '{op:4'hF, idx:32'h0000_0011, nbeats:3, last_hold:0, rsp_at:2, set_hold:0,
                    icm:64'h3000, phy:64'hA000, exp_lookups:0, exp_sets:0, exp_op:2'd0,
                    exp_err:2'd1, exp_set_cycle:-1};
        vecs[3] = '{op:OP_MOD, idx:32'h0000_0042, nbeats:1, last_hold:0, rsp_at:2, set_hold:0,
                    icm:64'h4000, phy:64'hB000, exp_lookups:1, exp_sets:0, exp_op:2'd0,
                    exp_err:2'd2, exp_set_cycle:-1};
        vecs[4] = '{op:OP_ALL, idx:32'h0000_0099, nbeats:4, last_hold:0, rsp_at:2, set_hold:0,
                    icm:64'h5000, phy:64'hC000, exp_lookups:1, exp_sets:0, exp_op:2'd0,
                    exp_err:2'd3, exp_set_cycle:-1};
        vecs[5] = '{op:OP_MOD, idx:32'h0000_1234, nbeats:2, last_hold:12, rsp_at:2, set_hold:5,
                    icm:64'hDEAD_0000_6000, phy:64'hBEEF_0000_D000, exp_lookups:1, exp_sets:1,
                    exp_op:2'd1, exp_err:2'd0, exp_set_cycle:18};
        vecs[6] = '{op:OP_ALL, idx:32'h0000_3FFF, nbeats:2, last_hold:0, rsp_at:2, set_hold:0,
                    icm:64'h7000, phy:64'hE000, exp_lookups:1, exp_sets:1, exp_op:2'd0,
                    exp_err:2'd0, exp_set_cycle:3};

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i], i);

        // Reset in the middle of COLLECT: one beat in, no response yet.
        head = '0;
        head[123:120] = OP_ALL;
        head[95:64]   = 32'h77;
        bus.req_valid    = 1'b1;
        bus.req_head     = head;
        bus.req_data     = beat_val(0, 9);
        bus.req_last     = 1'b0;
        bus.lookup_ready = 1'b1;
        @(negedge clk);
        chk("midrst lookup_valid", bus.lookup_valid, 1);
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.lookup_ready = 1'b0;
        chk("midrst rsp_ready", bus.rsp_ready, 1);
        chk("midrst req_ready", bus.req_ready, 1);
        chk("midrst err_code held", bus.err_code, 3);
        rst = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_cmd(vecs[6], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
